// File: rtl/serial_slave.sv
// Serial bus slave endpoint: deserialises address/rw/burst frames and moves byte beats to/from local memory.
// Optional build macro SLAVE_PARITY_EN adds an even-parity bit per beat and a sticky parity_err output.
`timescale 1ns/1ps

// state  | meaning
// IDLE   | waiting for valid, captures frame bit 0
// ADDR   | shifting in address bits 1..13 and burst bits 1..2
// DECODE | slave-ID compare, load local address and beat count
// WDATA  | shifting in one write beat
// WRITE  | commit beat to memory, advance address
// RFETCH | load read beat from memory
// RDATA  | shifting out one read beat
// DONE   | transaction over or ignored, wait for valid low
module serial_slave #(
    parameter int                    ID_WIDTH   = 2,
    parameter logic [ID_WIDTH-1:0]   SLAVE_ID   = 2'b10,
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    DATA_WIDTH = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic valid,
    input  logic addr_rx,
    input  logic rw_rx,
    input  logic burst_rx,
    input  logic data_rx,
    output logic slave_ready,
    output logic slave_valid,
    output logic data_tx,
    output logic slave_busy
`ifdef SLAVE_PARITY_EN
   ,output logic parity_err
`endif
);

    localparam int FRAME_BITS = ID_WIDTH + ADDR_WIDTH;
`ifdef SLAVE_PARITY_EN
    localparam int BEAT_BITS  = DATA_WIDTH + 1;
`else
    localparam int BEAT_BITS  = DATA_WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] BEAT_LAST  = CNT_W'(BEAT_BITS - 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, DECODE, WDATA, WRITE, RFETCH, RDATA, DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        bit_cnt;
    logic [FRAME_BITS-1:0]   frame_sh;
    logic                    rw_q;
    logic [2:0]              burst_q;
    logic [ADDR_WIDTH-1:0]   local_addr;
    logic [3:0]              beats;
    logic [BEAT_BITS-1:0]    shift_q;
    logic [BEAT_BITS-1:0]    fetch_word;
    logic [DATA_WIDTH-1:0]   rd_byte;
    logic                    wr_ok;
    logic                    mem_we;

    logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

    assign rd_byte = mem[local_addr];
`ifdef SLAVE_PARITY_EN
    assign fetch_word = {^rd_byte, rd_byte};
    assign wr_ok      = ~(^shift_q);
`else
    assign fetch_word = rd_byte;
    assign wr_ok      = 1'b1;
`endif
    // An aborting frame (valid low) never commits the beat sitting in WRITE.
    assign mem_we = (state_q == WRITE) && valid && wr_ok;

    always_ff @(posedge clock) begin
        if (mem_we)
            mem[local_addr] <= shift_q[DATA_WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (valid) state_d = ADDR;
            ADDR:   if (!valid) state_d = IDLE;
                    else if (bit_cnt == FRAME_LAST) state_d = DECODE;
            DECODE: if (!valid) state_d = IDLE;
                    else if (frame_sh[FRAME_BITS-1 -: ID_WIDTH] != SLAVE_ID) state_d = DONE;
                    else state_d = rw_q ? RFETCH : WDATA;
            WDATA:  if (!valid) state_d = IDLE;
                    else if (bit_cnt == BEAT_LAST) state_d = WRITE;
            WRITE:  if (!valid) state_d = IDLE;
                    else state_d = (beats == 4'd1) ? DONE : WDATA;
            RFETCH: if (!valid) state_d = IDLE;
                    else state_d = RDATA;
            RDATA:  if (!valid) state_d = IDLE;
                    else if (bit_cnt == BEAT_LAST) state_d = (beats == 4'd1) ? DONE : RFETCH;
            DONE:   if (!valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bit_cnt     <= '0;
            frame_sh    <= '0;
            rw_q        <= 1'b0;
            burst_q     <= '0;
            local_addr  <= '0;
            beats       <= '0;
            shift_q     <= '0;
            slave_ready <= 1'b1;
            slave_valid <= 1'b0;
            data_tx     <= 1'b0;
            slave_busy  <= 1'b0;
`ifdef SLAVE_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            slave_ready <= (state_d == IDLE) || (state_d == WDATA);
            slave_valid <= (state_d == RDATA);
            slave_busy  <= (state_d != IDLE);
            // Outputs are registered, so present the bit that shift_q will hold next.
            if (state_d == RDATA)
                data_tx <= (state_q == RFETCH) ? fetch_word[0] : shift_q[1];
            else
                data_tx <= 1'b0;

            case (state_q)
                IDLE: if (valid) begin
                    frame_sh <= {{(FRAME_BITS-1){1'b0}}, addr_rx};
                    rw_q     <= rw_rx;
                    burst_q  <= {2'b00, burst_rx};
                    bit_cnt  <= CNT_W'(1);
`ifdef SLAVE_PARITY_EN
                    parity_err <= 1'b0;
`endif
                end
                ADDR: begin
                    frame_sh[bit_cnt] <= addr_rx;
                    if (bit_cnt == CNT_W'(1)) burst_q[1] <= burst_rx;
                    if (bit_cnt == CNT_W'(2)) burst_q[2] <= burst_rx;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
                DECODE: begin
                    local_addr <= frame_sh[ADDR_WIDTH-1:0];
                    beats      <= {1'b0, burst_q} + 4'd1;
                    bit_cnt    <= '0;
                end
                WDATA: begin
                    shift_q <= {data_rx, shift_q[BEAT_BITS-1:1]};
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
                WRITE: begin
                    local_addr <= local_addr + ADDR_WIDTH'(1);
                    beats      <= beats - 4'd1;
                    bit_cnt    <= '0;
`ifdef SLAVE_PARITY_EN
                    if (valid && !wr_ok) parity_err <= 1'b1;
`endif
                end
                RFETCH: begin
                    shift_q <= fetch_word;
                    bit_cnt <= '0;
                end
                RDATA: begin
                    shift_q <= {1'b0, shift_q[BEAT_BITS-1:1]};
                    if (bit_cnt == BEAT_LAST) begin
                        local_addr <= local_addr + ADDR_WIDTH'(1);
                        beats      <= beats - 4'd1;
                        bit_cnt    <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_slave.sv
// Directed self-checking bench for serial_slave: reset, write/read, ID filter, burst wrap, abort, parity.
`timescale 1ns/1ps

module tb_serial_slave;

`ifdef SLAVE_PARITY_EN
    localparam int BB = 9;
    logic parity_err;
`else
    localparam int BB = 8;
`endif

    logic clock = 1'b0;
    logic reset_n, valid, addr_rx, rw_rx, burst_rx, data_rx;
    logic slave_ready, slave_valid, data_tx, slave_busy;
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    serial_slave dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .valid       (valid),
        .addr_rx     (addr_rx),
        .rw_rx       (rw_rx),
        .burst_rx    (burst_rx),
        .data_rx     (data_rx),
        .slave_ready (slave_ready),
        .slave_valid (slave_valid),
        .data_tx     (data_tx),
        .slave_busy  (slave_busy)
`ifdef SLAVE_PARITY_EN
       ,.parity_err  (parity_err)
`endif
    );

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic send_header(input logic [13:0] a, input logic rw, input logic [2:0] b);
        for (int i = 0; i < 14; i++) begin
            valid   = 1'b1;
            addr_rx = a[i];
            rw_rx   = rw;
            if (i < 3) burst_rx = b[i];
            else       burst_rx = 1'b0;
            @(negedge clock);
        end
        addr_rx  = 1'b0;
        burst_rx = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] byte_v, input logic bad_par);
        for (int j = 0; j < 8; j++) begin
            data_rx = byte_v[j];
            @(negedge clock);
        end
`ifdef SLAVE_PARITY_EN
        data_rx = (^byte_v) ^ bad_par;
        @(negedge clock);
`else
        data_rx = bad_par & 1'b0;
`endif
        data_rx = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] id, input logic [11:0] la, input logic [2:0] b,
                            input logic [63:0] d, input logic bad_par);
        send_header({id, la}, 1'b0, b);
        @(negedge clock);
        for (int k = 0; k <= int'(b); k++) begin
            send_beat(d[8*k +: 8], bad_par);
            @(negedge clock);
        end
        valid = 1'b0;
        @(negedge clock);
    endtask

    // Collects read bits; vbad counts cycles where slave_valid had the wrong level.
    task automatic do_read(input logic [11:0] la, input logic [2:0] b, output logic [63:0] got,
                           output logic [7:0] got_par, output int vbad,
                           output logic done_ok, output logic idle_ok);
        got = '0; got_par = '0; vbad = 0;
        send_header({2'b10, la}, 1'b1, b);
        @(negedge clock);
        for (int k = 0; k <= int'(b); k++) begin
            if (slave_valid !== 1'b0) vbad++;
            @(negedge clock);
            for (int j = 0; j < BB; j++) begin
                if (slave_valid !== 1'b1) vbad++;
                if (j < 8) got[8*k + j] = data_tx;
                else       got_par[k]   = data_tx;
                @(negedge clock);
            end
        end
        done_ok = (slave_valid === 1'b0) && (slave_ready === 1'b0) && (slave_busy === 1'b1);
        valid = 1'b0;
        rw_rx = 1'b0;
        @(negedge clock);
        idle_ok = (slave_ready === 1'b1) && (slave_busy === 1'b0) && (slave_valid === 1'b0);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; valid = 0; addr_rx = 0; rw_rx = 0; burst_rx = 0; data_rx = 0;
        repeat (2) @(negedge clock);
        checks++; if (slave_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", slave_ready); end
        checks++; if (slave_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", slave_valid); end
        checks++; if (data_tx !== 1'b0) begin errors++; $display("FAIL reset_data_tx: got %b want 0", data_tx); end
        checks++; if (slave_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", slave_busy); end
        reset_n = 1'b1;
        @(negedge clock);
        checks++; if (slave_busy !== 1'b0 || slave_ready !== 1'b1) begin
            errors++; $display("FAIL idle_after_reset: busy=%b ready=%b want 0/1", slave_busy, slave_ready);
        end
    endtask

    task automatic test_single_write_read;
        logic [63:0] got; logic [7:0] gp; int vbad; logic d_ok, i_ok;
        do_write(2'b10, 12'hCB2, 3'd0, 64'hD5, 1'b0);
        checks++; if (dut.mem[12'hCB2] !== 8'hD5) begin
            errors++; $display("FAIL single_mem: mem[CB2]=%h want d5", dut.mem[12'hCB2]);
        end
        do_read(12'hCB2, 3'd0, got, gp, vbad, d_ok, i_ok);
        checks++; if (got[7:0] !== 8'hD5) begin errors++; $display("FAIL single_read: got %h want d5", got[7:0]); end
        checks++; if (vbad != 0) begin errors++; $display("FAIL single_valid: %0d bad cycles want 0", vbad); end
        checks++; if (d_ok !== 1'b1) begin errors++; $display("FAIL single_done: got %b want 1", d_ok); end
        checks++; if (i_ok !== 1'b1) begin errors++; $display("FAIL single_idle: got %b want 1", i_ok); end
`ifdef SLAVE_PARITY_EN
        checks++; if (gp[0] !== 1'b1) begin errors++; $display("FAIL single_parity_bit: got %b want 1", gp[0]); end
`endif
    endtask

    task automatic test_id_mismatch;
        logic [63:0] got; logic [7:0] gp; int vbad; logic d_ok, i_ok;
        logic [7:0] aa;
        aa = 8'hAA;
        send_header(14'b01110010110010, 1'b0, 3'd0);
        @(negedge clock);
        for (int j = 0; j < BB; j++) begin
            data_rx = (j < 8) ? aa[j] : 1'b0;
            checks++; if (slave_ready !== 1'b0 || slave_valid !== 1'b0 || slave_busy !== 1'b1) begin
                errors++;
                $display("FAIL idmis_hs cyc %0d: ready=%b valid=%b busy=%b want 0/0/1", j, slave_ready, slave_valid, slave_busy);
            end
            @(negedge clock);
        end
        valid = 1'b0; data_rx = 1'b0;
        @(negedge clock);
        checks++; if (slave_ready !== 1'b1 || slave_busy !== 1'b0) begin
            errors++; $display("FAIL idmis_idle: ready=%b busy=%b want 1/0", slave_ready, slave_busy);
        end
        do_read(12'hCB2, 3'd0, got, gp, vbad, d_ok, i_ok);
        checks++; if (got[7:0] !== 8'hD5) begin errors++; $display("FAIL idmis_mem: got %h want d5", got[7:0]); end
    endtask

    task automatic test_burst_wrap;
        logic [63:0] got; logic [7:0] gp; int vbad; logic d_ok, i_ok;
        do_write(2'b10, 12'hFFE, 3'd3, 64'h44332211, 1'b0);
        checks++; if (dut.mem[12'h000] !== 8'h33) begin
            errors++; $display("FAIL wrap_mem0: mem[000]=%h want 33", dut.mem[12'h000]);
        end
        do_read(12'hFFE, 3'd3, got, gp, vbad, d_ok, i_ok);
        checks++; if (got[31:0] !== 32'h44332211) begin errors++; $display("FAIL wrap_read: got %h want 44332211", got[31:0]); end
        checks++; if (vbad != 0) begin errors++; $display("FAIL wrap_valid_gaps: %0d bad cycles want 0", vbad); end
        checks++; if (d_ok !== 1'b1 || i_ok !== 1'b1) begin errors++; $display("FAIL wrap_end: done=%b idle=%b want 1/1", d_ok, i_ok); end
`ifdef SLAVE_PARITY_EN
        checks++; if (gp[3:0] !== 4'b0000) begin errors++; $display("FAIL wrap_parity_bits: got %b want 0000", gp[3:0]); end
`endif
    endtask

    task automatic test_abort;
        logic [63:0] got; logic [7:0] gp; int vbad; logic d_ok, i_ok;
        logic [7:0] f0;
        f0 = 8'hF0;
        do_write(2'b10, 12'h011, 3'd0, 64'h5A, 1'b0);
        send_header({2'b10, 12'h010}, 1'b0, 3'd1);
        @(negedge clock);
        send_beat(8'h3C, 1'b0);
        @(negedge clock);
        for (int j = 0; j < 5; j++) begin
            data_rx = f0[j];
            @(negedge clock);
        end
        valid = 1'b0; data_rx = 1'b0;
        @(negedge clock);
        checks++; if (slave_busy !== 1'b0 || slave_ready !== 1'b1) begin
            errors++; $display("FAIL abort_idle: busy=%b ready=%b want 0/1", slave_busy, slave_ready);
        end
        do_read(12'h010, 3'd1, got, gp, vbad, d_ok, i_ok);
        checks++; if (got[7:0] !== 8'h3C) begin errors++; $display("FAIL abort_beat0: got %h want 3c", got[7:0]); end
        checks++; if (got[15:8] !== 8'h5A) begin errors++; $display("FAIL abort_beat1: got %h want 5a", got[15:8]); end
    endtask

    task automatic test_reset_mid;
        logic [63:0] got; logic [7:0] gp; int vbad; logic d_ok, i_ok;
        send_header({2'b10, 12'hCB2}, 1'b1, 3'd0);
        repeat (3) @(negedge clock);
        checks++; if (slave_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: valid=%b want 1", slave_valid); end
        reset_n = 1'b0;
        #1;
        checks++; if (slave_valid !== 1'b0 || data_tx !== 1'b0 || slave_ready !== 1'b1 || slave_busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: valid=%b tx=%b ready=%b busy=%b want 0/0/1/0", slave_valid, data_tx, slave_ready, slave_busy);
        end
        valid = 1'b0; rw_rx = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        do_read(12'hCB2, 3'd0, got, gp, vbad, d_ok, i_ok);
        checks++; if (got[7:0] !== 8'hD5 || vbad != 0) begin
            errors++; $display("FAIL rstmid_after: got %h vbad=%0d want d5/0", got[7:0], vbad);
        end
    endtask

`ifdef SLAVE_PARITY_EN
    task automatic test_parity;
        logic [63:0] got; logic [7:0] gp; int vbad; logic d_ok, i_ok;
        do_write(2'b10, 12'h100, 3'd0, 64'h77, 1'b0);
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL par_good: err=%b want 0", parity_err); end
        do_write(2'b10, 12'h100, 3'd0, 64'hD5, 1'b1);
        checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL par_bad: err=%b want 1", parity_err); end
        do_read(12'h100, 3'd0, got, gp, vbad, d_ok, i_ok);
        checks++; if (got[7:0] !== 8'h77) begin errors++; $display("FAIL par_mem: got %h want 77", got[7:0]); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL par_clear: err=%b want 0", parity_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_write_read();
        test_id_mismatch();
        test_burst_wrap();
        test_abort();
        test_reset_mid();
`ifdef SLAVE_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
